exp3_gravador_memoria: RTL and testbench

Write-side counterpart of the Experience 3 sequential-compare circuit: it loads the 16×4 sequence memory that the compare circuit reads back. It records the switch value `chaves` into consecutive addresses, one address per rising edge of the `gravar` button, under a small control FSM. A second, independent asynchronous read port exposes the stored data to the reader/comparator datapath. Debug outputs are raw 4-bit values; the top level drives them through `hexa7seg`.

---
 rtl/exp3_gravador_memoria.sv | 112 +++++++++++
 tb/tb_exp3_gravador_memoria.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/exp3_gravador_memoria.sv
// exp3_gravador_memoria
// Write side of the Experience 3 sequence memory. Each rising edge of
// `gravar` records `chaves` into the next address of a 16x4 register array.
// A small control FSM sequences the writes. An independent combinational
// read port serves the compare datapath.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous, active-low
//   iniciar          starts a recording session (sampled in INICIAL / FIM)
//   gravar           record button, rising edge acts
//   chaves [3:0]     data to record
//   endereco_leitura read-port address
//   dado_leitura     mem[endereco_leitura], combinational
//   pronto           high while in FIM
//   ocupado          high in PREPARA, ESPERA, GRAVA, PROXIMO
//   db_endereco      current write address
//   db_ultimo_dado   last value captured from chaves
//   db_estado        state code
module exp3_gravador_memoria #(
  parameter int unsigned N_POSICOES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       gravar,
  input  logic [3:0] chaves,
  input  logic [3:0] endereco_leitura,
  output logic [3:0] dado_leitura,
  output logic       pronto,
  output logic       ocupado,
  output logic [3:0] db_endereco,
  output logic [3:0] db_ultimo_dado,
  output logic [3:0] db_estado
);

  localparam int unsigned AW          = 4;
  localparam int unsigned DW          = 4;
  localparam int unsigned PROFUNDIDADE = 16;
  localparam logic [AW-1:0] ULTIMO    = AW'(N_POSICOES - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    PREPARA = 4'h1,
    ESPERA  = 4'h2,
    GRAVA   = 4'h3,
    PROXIMO = 4'h4,
    FIM     = 4'hF
  } estado_t;

  estado_t          estado;
  estado_t          estado_prox;
  logic             gravar_ant;
  logic             borda;
  logic [AW-1:0]    endereco;
  logic [DW-1:0]    dado;
  logic [DW-1:0]    mem [PROFUNDIDADE];

  // gravar_ant resets high so a button held through reset release is not an edge
  assign borda = gravar & ~gravar_ant;

  // Next-state decode
  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL: if (iniciar) estado_prox = PREPARA;
      PREPARA: estado_prox = ESPERA;
      ESPERA:  if (borda) estado_prox = GRAVA;
      GRAVA:   estado_prox = (endereco == ULTIMO) ? FIM : PROXIMO;
      PROXIMO: estado_prox = ESPERA;
      FIM:     if (iniciar) estado_prox = PREPARA;
      default: estado_prox = INICIAL;
    endcase
  end

  // Control state, datapath registers and status outputs (decoded from next state
  // so they change together with db_estado)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      gravar_ant <= 1'b1;
      endereco   <= '0;
      dado       <= '0;
      pronto     <= 1'b0;
      ocupado    <= 1'b0;
    end else begin
      estado     <= estado_prox;
      gravar_ant <= gravar;
      if (estado == PREPARA) endereco <= '0;
      else if (estado == PROXIMO) endereco <= endereco + AW'(1);
      if (estado == ESPERA && borda) dado <= chaves;
      pronto     <= (estado_prox == FIM);
      ocupado    <= (estado_prox == PREPARA) || (estado_prox == ESPERA) ||
                    (estado_prox == GRAVA)   || (estado_prox == PROXIMO);
    end
  end

  // Storage array; reset clears every entry, written only in GRAVA
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(PROFUNDIDADE); i++) mem[i] <= '0;
    end else if (estado == GRAVA) begin
      mem[endereco] <= dado;
    end
  end

  assign dado_leitura   = mem[endereco_leitura];
  assign db_endereco    = endereco;
  assign db_ultimo_dado = dado;
  assign db_estado      = estado;

endmodule

// File: tb/tb_exp3_gravador_memoria.sv
module tb_exp3_gravador_memoria;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, gravar;
  logic       iniciar4, gravar4;
  logic [3:0] chaves, endereco_leitura;

  logic [3:0] dado_leitura, db_endereco, db_ultimo_dado, db_estado;
  logic       pronto, ocupado;
  logic [3:0] dado_leitura4, db_endereco4, db_ultimo_dado4, db_estado4;
  logic       pronto4, ocupado4;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] esperado_q[$];

  always #5 clock = ~clock;

  exp3_gravador_memoria #(.N_POSICOES(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .gravar(gravar),
    .chaves(chaves), .endereco_leitura(endereco_leitura),
    .dado_leitura(dado_leitura), .pronto(pronto), .ocupado(ocupado),
    .db_endereco(db_endereco), .db_ultimo_dado(db_ultimo_dado), .db_estado(db_estado)
  );

  exp3_gravador_memoria #(.N_POSICOES(4)) dut4 (
    .clock(clock), .reset(reset), .iniciar(iniciar4), .gravar(gravar4),
    .chaves(chaves), .endereco_leitura(endereco_leitura),
    .dado_leitura(dado_leitura4), .pronto(pronto4), .ocupado(ocupado4),
    .db_endereco(db_endereco4), .db_ultimo_dado(db_ultimo_dado4), .db_estado(db_estado4)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One press with 4-cycle spacing; returns back in ESPERA (or FIM)
  task automatic press(input bit alt, input logic [3:0] v);
    @(negedge clock);
    chaves = v;
    if (alt) gravar4 = 1'b1; else gravar = 1'b1;
    @(negedge clock);
    gravar  = 1'b0;
    gravar4 = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic start(input bit alt);
    @(negedge clock);
    if (alt) iniciar4 = 1'b1; else iniciar = 1'b1;
    @(negedge clock);
    iniciar  = 1'b0;
    iniciar4 = 1'b0;
    if (!alt) chk("start_prepara", db_estado, 4'h1);
    @(negedge clock);
    if (!alt) chk("start_espera", db_estado, 4'h2);
  endtask

  task automatic ler_fila(input bit alt, input logic [3:0] addr, input string tag);
    logic [3:0] exp;
    endereco_leitura = addr;
    #1;
    exp = esperado_q.pop_front();
    chk(tag, alt ? dado_leitura4 : dado_leitura, exp);
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; gravar = 1'b1; iniciar4 = 1'b0; gravar4 = 1'b0;
    chaves = 4'h0; endereco_leitura = 4'h0;

    // Reset with gravar held high, then release
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_estado",   db_estado, 4'h0);
    chk("rst_pronto",   pronto, 1'b0);
    chk("rst_ocupado",  ocupado, 1'b0);
    chk("rst_endereco", db_endereco, 4'h0);
    chk("rst_dado",     db_ultimo_dado, 4'h0);
    for (int a = 0; a < 16; a++) esperado_q.push_back(4'h0);
    for (int a = 0; a < 16; a++) ler_fila(1'b0, 4'(a), "rst_mem");
    gravar = 1'b0;

    // Full 16-position session
    start(1'b0);
    chk("sessao_ocupado", ocupado, 1'b1);
    for (int i = 0; i < 16; i++) begin
      esperado_q.push_back(4'(i));
      press(1'b0, 4'(i));
      chk("sessao_endereco", db_endereco, (i < 15) ? 4'(i + 1) : 4'hF);
      chk("sessao_ultimo", db_ultimo_dado, 4'(i));
      if (i < 15) chk("sessao_pronto_baixo", pronto, 1'b0);
    end
    chk("fim_pronto",  pronto, 1'b1);
    chk("fim_estado",  db_estado, 4'hF);
    chk("fim_ocupado", ocupado, 1'b0);
    for (int a = 0; a < 16; a++) ler_fila(1'b0, 4'(a), "sessao_mem");
    repeat (3) @(negedge clock);
    chk("fim_segura", pronto, 1'b1);

    // Held gravar: exactly one write in a new session from address 0
    start(1'b0);
    chk("novo_endereco", db_endereco, 4'h0);
    @(negedge clock);
    chaves = 4'h9; gravar = 1'b1;
    repeat (10) @(negedge clock);
    gravar = 1'b0;
    repeat (3) @(negedge clock);
    chk("segura_endereco", db_endereco, 4'h1);
    chk("segura_ultimo",   db_ultimo_dado, 4'h9);
    chk("segura_estado",   db_estado, 4'h2);
    esperado_q.push_back(4'h9);
    esperado_q.push_back(4'h1);
    ler_fila(1'b0, 4'h0, "segura_mem0");
    ler_fila(1'b0, 4'h1, "segura_mem1");

    // Second edge during GRAVA/PROXIMO discarded; write latency on read port
    @(negedge clock);
    chaves = 4'h5; gravar = 1'b1;
    @(negedge clock);
    gravar = 1'b0;
    chk("rep_grava", db_estado, 4'h3);
    chk("rep_ultimo", db_ultimo_dado, 4'h5);
    endereco_leitura = 4'h1;
    #1 chk("rep_mem_antigo", dado_leitura, 4'h1);
    @(negedge clock);
    chaves = 4'h6; gravar = 1'b1;
    chk("rep_proximo", db_estado, 4'h4);
    chk("rep_mem_novo", dado_leitura, 4'h5);
    @(negedge clock);
    gravar = 1'b0;
    chk("rep_espera", db_estado, 4'h2);
    repeat (3) @(negedge clock);
    chk("rep_endereco", db_endereco, 4'h2);
    chk("rep_ultimo2", db_ultimo_dado, 4'h5);
    chk("rep_estado2", db_estado, 4'h2);
    esperado_q.push_back(4'h5);
    esperado_q.push_back(4'h2);
    ler_fila(1'b0, 4'h1, "rep_mem1");
    ler_fila(1'b0, 4'h2, "rep_mem2");

    // N_POSICOES = 4 instance
    start(1'b1);
    chk("n4_estado_ini", db_estado4, 4'h2);
    for (int i = 0; i < 4; i++) begin
      esperado_q.push_back(4'(4'hA + i));
      press(1'b1, 4'(4'hA + i));
      if (i < 3) chk("n4_pronto_baixo", pronto4, 1'b0);
    end
    esperado_q.push_back(4'h0);
    chk("n4_pronto",   pronto4, 1'b1);
    chk("n4_estado",   db_estado4, 4'hF);
    chk("n4_endereco", db_endereco4, 4'h3);
    for (int a = 0; a < 5; a++) ler_fila(1'b1, 4'(a), "n4_mem");

    // Reset asserted mid-session at address 7
    for (int i = 0; i < 5; i++) press(1'b0, 4'(4'h3 + i));
    chk("meio_endereco", db_endereco, 4'h7);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("meio_estado",   db_estado, 4'h0);
    chk("meio_endereco0", db_endereco, 4'h0);
    chk("meio_dado",     db_ultimo_dado, 4'h0);
    chk("meio_ocupado",  ocupado, 1'b0);
    chk("meio_pronto",   pronto, 1'b0);
    for (int a = 0; a < 8; a++) esperado_q.push_back(4'h0);
    for (int a = 0; a < 8; a++) ler_fila(1'b0, 4'(a), "meio_mem");
    @(negedge clock);
    reset = 1'b1;
    start(1'b0);
    press(1'b0, 4'hE);
    chk("reinicio_endereco", db_endereco, 4'h1);
    chk("reinicio_ultimo",   db_ultimo_dado, 4'hE);
    esperado_q.push_back(4'hE);
    esperado_q.push_back(4'h0);
    ler_fila(1'b0, 4'h0, "reinicio_mem0");
    ler_fila(1'b0, 4'h1, "reinicio_mem1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
